mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// M-stage load/store unit: one bus transaction per access through an IDLE/REQ/DONE FSM with a timeout.
// Define MEM_ACCESS_ALIGN_EXC_EN to raise adel/ades on misaligned half/word accesses instead of issuing them.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signedM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        stallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        adel,
  output logic        ades,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  stateT       state;
  logic [15:0] toCnt;
  logic [1:0]  sizeQ;
  logic        signedQ;
  logic [1:0]  offQ;

  logic        isHalf;
  logic        isWord;
  logic        misaligned;
  logic        startAcc;
  logic [3:0]  nextBe;
  logic [31:0] nextWdata;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;

  assign isHalf = (sizeM == 2'b01);
  assign isWord = sizeM[1];

`ifdef MEM_ACCESS_ALIGN_EXC_EN
  assign misaligned = (isHalf & addrM[0]) | (isWord & (addrM[1:0] != 2'b00));
  assign adel = ~rst & (state == IDLE) & memenM & misaligned & ~memwriteM;
  assign ades = ~rst & (state == IDLE) & memenM & misaligned & memwriteM;
`else
  // Offending low address bits are simply dropped by the lane logic below.
  assign misaligned = 1'b0;
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  assign startAcc = (state == IDLE) & memenM & ~misaligned;
  assign stallM   = startAcc | (state == REQ);
  assign dbgState = state;

  always_comb begin
    nextBe    = 4'b1111;
    nextWdata = wdataM;
    if (sizeM == 2'b00) begin
      nextBe    = 4'b0001 << addrM[1:0];
      nextWdata = {4{wdataM[7:0]}};
    end else if (isHalf) begin
      nextBe    = addrM[1] ? 4'b1100 : 4'b0011;
      nextWdata = {2{wdataM[15:0]}};
    end
  end

  // Lane extraction uses only the captured access attributes, never the live M-stage inputs.
  always_comb begin
    laneByte = bus_rdata[7:0];
    case (offQ)
      2'd1:    laneByte = bus_rdata[15:8];
      2'd2:    laneByte = bus_rdata[23:16];
      2'd3:    laneByte = bus_rdata[31:24];
      default: laneByte = bus_rdata[7:0];
    endcase
    laneHalf = offQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    loadData = bus_rdata;
    if (sizeQ == 2'b00)
      loadData = {{24{signedQ & laneByte[7]}}, laneByte};
    else if (sizeQ == 2'b01)
      loadData = {{16{signedQ & laneHalf[15]}}, laneHalf};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      toCnt     <= '0;
      rdataM    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      sizeQ     <= '0;
      signedQ   <= 1'b0;
      offQ      <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (startAcc) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= memwriteM;
            bus_addr  <= {addrM[31:2], 2'b00};
            bus_be    <= nextBe;
            bus_wdata <= nextWdata;
            sizeQ     <= sizeM;
            signedQ   <= signedM;
            offQ      <= addrM[1:0];
            toCnt     <= '0;
          end
        end
        REQ: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) rdataM <= loadData;
          end else if (toCnt == LAST_WAIT) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            toCnt   <= toCnt + 16'd1;
            if (!bus_we) rdataM <= '0;
          end else begin
            toCnt <= toCnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
